// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: owner tags and the memory command.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_IFETCH = 2'd1,
    TAG_DATA   = 2'd2
  } owner_t;

  typedef struct packed {
    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
  } cmd_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant logic for the two memory requesters: fixed data priority, or round-robin
// on contested cycles when MEM_ARB_RR_EN is defined.
module mem_arb_grant
(
  input  logic Clock,
  input  logic nReset,
  input  logic i_req,
  input  logic d_req,
  output logic i_grant_c,
  output logic d_grant_c
);

`ifdef MEM_ARB_RR_EN
  // High when the instruction port wins the next contested cycle.
  logic favour_i_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      favour_i_q <= 1'b0;
    end else if (i_req && d_req) begin
      favour_i_q <= ~favour_i_q;
    end
  end

  always_comb begin
    i_grant_c = 1'b0;
    d_grant_c = 1'b0;
    if (nReset) begin
      if (i_req && d_req) begin
        i_grant_c = favour_i_q;
        d_grant_c = ~favour_i_q;
      end else begin
        i_grant_c = i_req;
        d_grant_c = d_req;
      end
    end
  end
`else
  logic unused_clock;
  assign unused_clock = Clock;

  always_comb begin
    i_grant_c = 1'b0;
    d_grant_c = 1'b0;
    if (nReset) begin
      d_grant_c = d_req;
      i_grant_c = i_req && !d_req;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one synchronous memory port.
// Optional round-robin arbitration via MEM_ARB_RR_EN (default: data port priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddressSize = ADDR_W,
  parameter int unsigned WordSize    = DATA_W
)
(
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   I_Req,
  input  logic [AddressSize-1:0] I_Address,
  output logic                   I_Ready,
  output logic                   I_Valid,
  output logic [WordSize-1:0]    I_ReadData,
  input  logic                   D_Req,
  input  logic                   D_Write,
  input  logic [AddressSize-1:0] D_Address,
  input  logic [WordSize-1:0]    D_WriteData,
  output logic                   D_Ready,
  output logic                   D_Valid,
  output logic [WordSize-1:0]    D_ReadData,
  output logic                   Mem_ReadEn,
  output logic                   Mem_WriteEn,
  output logic [AddressSize-1:0] Mem_Address,
  output logic [WordSize-1:0]    Mem_WriteData,
  input  logic [WordSize-1:0]    Mem_ReadData
);

  logic   i_grant_c;
  logic   d_grant_c;
  cmd_t   cmd_d;
  cmd_t   cmd_q;
  owner_t tag_d;
  owner_t tag1_q;
  owner_t tag2_q;

  mem_arb_grant u_grant (
    .Clock     (Clock),
    .nReset    (nReset),
    .i_req     (I_Req),
    .d_req     (D_Req),
    .i_grant_c (i_grant_c),
    .d_grant_c (d_grant_c)
  );

  // Build the next memory command and the owner of any read it starts.
  always_comb begin
    cmd_d = '0;
    tag_d = TAG_NONE;
    if (d_grant_c) begin
      cmd_d.read_en    = ~D_Write;
      cmd_d.write_en   = D_Write;
      cmd_d.address    = ADDR_W'(D_Address);
      cmd_d.write_data = D_Write ? DATA_W'(D_WriteData) : '0;
      tag_d            = D_Write ? TAG_NONE : TAG_DATA;
    end else if (i_grant_c) begin
      cmd_d.read_en = 1'b1;
      cmd_d.address = ADDR_W'(I_Address);
      tag_d         = TAG_IFETCH;
    end
  end

  // Command register plus two tag stages matching the memory's read latency.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cmd_q  <= '0;
      tag1_q <= TAG_NONE;
      tag2_q <= TAG_NONE;
    end else begin
      cmd_q  <= cmd_d;
      tag1_q <= tag_d;
      tag2_q <= tag1_q;
    end
  end

  assign I_Ready       = i_grant_c;
  assign D_Ready       = d_grant_c;
  assign Mem_ReadEn    = cmd_q.read_en;
  assign Mem_WriteEn   = cmd_q.write_en;
  assign Mem_Address   = AddressSize'(cmd_q.address);
  assign Mem_WriteData = WordSize'(cmd_q.write_data);

  // Read data is steered only to the owning port and forced to zero otherwise.
  assign I_Valid    = (tag2_q == TAG_IFETCH);
  assign D_Valid    = (tag2_q == TAG_DATA);
  assign I_ReadData = I_Valid ? Mem_ReadData : '0;
  assign D_ReadData = D_Valid ? Mem_ReadData : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected reads,
// a monitor pops them when I_Valid/D_Valid appear.
module tb_mem_arbiter;

  logic        Clock;
  logic        nReset;
  logic        I_Req;
  logic [15:0] I_Address;
  logic        I_Ready;
  logic        I_Valid;
  logic [31:0] I_ReadData;
  logic        D_Req;
  logic        D_Write;
  logic [15:0] D_Address;
  logic [31:0] D_WriteData;
  logic        D_Ready;
  logic        D_Valid;
  logic [31:0] D_ReadData;
  logic        Mem_ReadEn;
  logic        Mem_WriteEn;
  logic [15:0] Mem_Address;
  logic [31:0] Mem_WriteData;
  logic [31:0] Mem_ReadData;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] mem [0:65535];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          done = 0;

  mem_arbiter #(.AddressSize(16), .WordSize(32)) dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .I_Req         (I_Req),
    .I_Address     (I_Address),
    .I_Ready       (I_Ready),
    .I_Valid       (I_Valid),
    .I_ReadData    (I_ReadData),
    .D_Req         (D_Req),
    .D_Write       (D_Write),
    .D_Address     (D_Address),
    .D_WriteData   (D_WriteData),
    .D_Ready       (D_Ready),
    .D_Valid       (D_Valid),
    .D_ReadData    (D_ReadData),
    .Mem_ReadEn    (Mem_ReadEn),
    .Mem_WriteEn   (Mem_WriteEn),
    .Mem_Address   (Mem_Address),
    .Mem_WriteData (Mem_WriteData),
    .Mem_ReadData  (Mem_ReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Single-port synchronous memory: registered read, zero when not reading.
  always @(posedge Clock) begin
    if (Mem_WriteEn) mem[Mem_Address] <= Mem_WriteData;
    Mem_ReadData <= Mem_ReadEn ? mem[Mem_Address] : 32'h0;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Present one request, wait (bounded) for acceptance, then check the command it produced.
  task automatic issue(input bit port_d, input bit wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, output int acc);
    int waited = 0;
    bit ok = 0;
    acc = -1;
    if (port_d) begin
      D_Req = 1'b1; D_Write = wr; D_Address = addr; D_WriteData = wdata;
    end else begin
      I_Req = 1'b1; I_Address = addr;
    end
    while (!ok && waited < 20) begin
      #1;
      if (port_d ? D_Ready : I_Ready) begin
        ok = 1;
        acc = cyc;
        if (!wr) begin
          if (port_d) dq.push_back('{exp, acc + 2});
          else        iq.push_back('{exp, acc + 2});
        end
      end
      @(negedge Clock);
      if (!ok) waited++;
    end
    if (port_d) D_Req = 1'b0;
    else        I_Req = 1'b0;
    if (!ok) begin
      check(port_d ? "d_accept_timeout" : "i_accept_timeout", 64'd0, 64'd1);
    end else begin
      check("mem_readen",    64'(Mem_ReadEn), 64'(!wr));
      check("mem_writeen",   64'(Mem_WriteEn), 64'(wr));
      check("mem_address",   64'(Mem_Address), 64'(addr));
      check("mem_writedata", 64'(Mem_WriteData), wr ? 64'(wdata) : 64'd0);
    end
  endtask

  // Monitor: pops expectations on Valid, checks zero data and Ready-without-Req otherwise.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge Clock);
      #2;
      if (I_Valid) begin
        if (iq.size() == 0) check("i_valid_unexpected", 64'd1, 64'd0);
        else begin
          e = iq.pop_front();
          check("i_rdata", 64'(I_ReadData), 64'(e.data));
          check("i_valid_cycle", 64'(cyc), 64'(e.due));
        end
      end else check("i_rdata_idle_zero", 64'(I_ReadData), 64'd0);
      if (D_Valid) begin
        if (dq.size() == 0) check("d_valid_unexpected", 64'd1, 64'd0);
        else begin
          e = dq.pop_front();
          check("d_rdata", 64'(D_ReadData), 64'(e.data));
          check("d_valid_cycle", 64'(cyc), 64'(e.due));
        end
      end else check("d_rdata_idle_zero", 64'(D_ReadData), 64'd0);
      if (I_Ready && !I_Req) check("i_ready_without_req", 64'd1, 64'd0);
      if (D_Ready && !D_Req) check("d_ready_without_req", 64'd1, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, n;
    int da[3];
    int ia[3];
    nReset = 1'b0; I_Req = 1'b0; I_Address = '0;
    D_Req = 1'b0; D_Write = 1'b0; D_Address = '0; D_WriteData = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h0000] = 32'd1; mem[16'h0001] = 32'd2; mem[16'h0002] = 32'd3; mem[16'h0003] = 32'd4;
    mem[16'h0020] = 32'h2020_2020; mem[16'h0030] = 32'h3030_3030;
    for (int k = 0; k < 3; k++) begin
      mem[16'h0040 + 16'(k)] = 32'h4000 + 32'(k);
      mem[16'h0050 + 16'(k)] = 32'h5000 + 32'(k);
    end

    // Reset state, with requests asserted to confirm Ready stays low.
    repeat (2) @(negedge Clock);
    I_Req = 1'b1; D_Req = 1'b1;
    #1;
    check("rst_i_ready", 64'(I_Ready), 64'd0);
    check("rst_d_ready", 64'(D_Ready), 64'd0);
    check("rst_mem_readen", 64'(Mem_ReadEn), 64'd0);
    check("rst_mem_writeen", 64'(Mem_WriteEn), 64'd0);
    check("rst_mem_address", 64'(Mem_Address), 64'd0);
    @(negedge Clock);
    I_Req = 1'b0; D_Req = 1'b0;
    nReset = 1'b1;

    // Idle for 10 cycles.
    repeat (10) begin
      @(negedge Clock);
      #1;
      check("idle_mem_readen", 64'(Mem_ReadEn), 64'd0);
      check("idle_mem_writeen", 64'(Mem_WriteEn), 64'd0);
      check("idle_i_valid", 64'(I_Valid), 64'd0);
      check("idle_d_valid", 64'(D_Valid), 64'd0);
    end

    // D write then I read of the same address on the next cycle.
    @(negedge Clock);
    issue(1, 1, 16'h0010, 32'hDEADBEEF, 32'h0, a0);
    issue(0, 0, 16'h0010, 32'h0, 32'hDEADBEEF, a1);
    check("raw_accept_gap", 64'(a1 - a0), 64'd1);
    repeat (4) @(negedge Clock);

    // Simultaneous requests from a fresh arbiter: data first.
    n = cyc;
    fork
      issue(1, 0, 16'h0020, 32'h0, 32'h2020_2020, a0);
      issue(0, 0, 16'h0030, 32'h0, 32'h3030_3030, a1);
    join
    check("both_d_accept_cycle", 64'(a0 - n), 64'd0);
    check("both_i_accept_cycle", 64'(a1 - n), 64'd1);
    repeat (4) @(negedge Clock);

    // Four back-to-back instruction fetches.
    n = cyc;
    for (int k = 0; k < 4; k++) begin
      issue(0, 0, 16'(k), 32'h0, 32'(k + 1), a0);
      check("burst_accept_cycle", 64'(a0 - n), 64'(k));
    end
    repeat (4) @(negedge Clock);

    // Reset one cycle after a D read is accepted: that read must never return.
    issue(1, 0, 16'h0020, 32'h0, 32'h2020_2020, a0);
    nReset = 1'b0;
    dq.delete();
    I_Req = 1'b1; D_Req = 1'b1;
    #1;
    check("mid_rst_i_ready", 64'(I_Ready), 64'd0);
    check("mid_rst_d_ready", 64'(D_Ready), 64'd0);
    check("mid_rst_mem_readen", 64'(Mem_ReadEn), 64'd0);
    check("mid_rst_mem_writeen", 64'(Mem_WriteEn), 64'd0);
    check("mid_rst_mem_address", 64'(Mem_Address), 64'd0);
    check("mid_rst_mem_wdata", 64'(Mem_WriteData), 64'd0);
    check("mid_rst_valids", 64'({I_Valid, D_Valid}), 64'd0);
    check("mid_rst_rdata", 64'({I_ReadData, D_ReadData}), 64'd0);
    @(negedge Clock);
    I_Req = 1'b0; D_Req = 1'b0;
    nReset = 1'b1;
    n = cyc;
    issue(0, 0, 16'h0001, 32'h0, 32'd2, a2);
    check("post_rst_accept_cycle", 64'(a2 - n), 64'd0);
    repeat (4) @(negedge Clock);

    // Both ports requesting continuously for six grants.
    n = cyc;
    fork
      for (int k = 0; k < 3; k++) issue(1, 0, 16'h0040 + 16'(k), 32'h0, 32'h4000 + 32'(k), da[k]);
      for (int k = 0; k < 3; k++) issue(0, 0, 16'h0050 + 16'(k), 32'h0, 32'h5000 + 32'(k), ia[k]);
    join
    for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
      check("rr_d_grant_cycle", 64'(da[k] - n), 64'(2 * k));
      check("rr_i_grant_cycle", 64'(ia[k] - n), 64'(2 * k + 1));
`else
      check("prio_d_grant_cycle", 64'(da[k] - n), 64'(k));
      check("prio_i_grant_cycle", 64'(ia[k] - n), 64'(k + 3));
`endif
    end
    repeat (5) @(negedge Clock);

    check("i_queue_drained", 64'(iq.size()), 64'd0);
    check("d_queue_drained", 64'(dq.size()), 64'd0);
    done = 1;
    @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
